// File: rtl/mips_stat_pkg.sv
// rtl/mips_stat_pkg.sv - counter indices, MIPS opcode constants and opcode classifier for perf_stats
package mips_stat_pkg;

    localparam int NUM_CNT = 7;

    localparam int IDX_CYCLES  = 0;
    localparam int IDX_RTYPE   = 1;
    localparam int IDX_ITYPE   = 2;
    localparam int IDX_JTYPE   = 3;
    localparam int IDX_MEM     = 4;
    localparam int IDX_BRANCH  = 5;
    localparam int IDX_UNKNOWN = 6;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_SLTI    = 6'b001010;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;

    // Class-counter hit mask for one retiring opcode; the CYCLES bit is never set here.
    // Loads/stores and branches hit MEM/BRANCH on top of ITYPE.
    function automatic logic [NUM_CNT-1:0] classify(input logic [5:0] op);
        logic [NUM_CNT-1:0] m;
        m = '0;
        case (op)
            OP_SPECIAL: m[IDX_RTYPE] = 1'b1;
            OP_LW, OP_SW: begin
                m[IDX_ITYPE] = 1'b1;
                m[IDX_MEM]   = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                m[IDX_ITYPE]  = 1'b1;
                m[IDX_BRANCH] = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI: m[IDX_ITYPE] = 1'b1;
            OP_J, OP_JAL: m[IDX_JTYPE] = 1'b1;
            default: m[IDX_UNKNOWN] = 1'b1;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/stat_counter.sv
// rtl/stat_counter.sv - single event counter with wrap/saturate behaviour and sticky overflow
// clk, rst : clock, synchronous active-high reset
// clr      : synchronous clear of count and overflow, wins over inc
// inc      : count one event this cycle
// q, ovf   : current count, sticky overflow flag
module stat_counter #(
    parameter int CNT_W    = 32,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q,
    output logic             ovf
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q   <= '0;
            ovf <= 1'b0;
        end else if (inc) begin
            if (&q) begin
                ovf <= 1'b1;
                // saturating counters hold all-ones, wrapping ones roll to zero
                if (SATURATE == 0) begin
                    q <= '0;
                end
            end else begin
                q <= q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/perf_stats.sv
// rtl/perf_stats.sv - MIPS retirement performance counters with snapshot bank and registered read port
// clk, rst          : clock, synchronous active-high reset
// instr_valid, op   : retiring instruction and its opcode
// run               : counting enable
// clr, snap         : clear live bank / copy live bank into snapshot bank
// rd_sel, rd_src    : read index (7 reads zero) and bank select (0 live, 1 snapshot)
// rd_data           : registered read data, one cycle after select
// ovf               : sticky overflow per counter index
module perf_stats
    import mips_stat_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [5:0]       op,
    input  logic             run,
    input  logic             clr,
    input  logic             snap,
    input  logic [2:0]       rd_sel,
    input  logic             rd_src,
    output logic [CNT_W-1:0] rd_data,
    output logic [6:0]       ovf
);

    logic [NUM_CNT-1:0] inc;
    logic [CNT_W-1:0]   live_q [NUM_CNT];
    logic [CNT_W-1:0]   snap_q [NUM_CNT];
    logic [CNT_W-1:0]   rd_mux;

    always_comb begin
        inc = '0;
        if (run) begin
            inc[IDX_CYCLES] = 1'b1;
            if (instr_valid) begin
                inc = inc | classify(op);
            end
        end
    end

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        stat_counter #(
            .CNT_W    (CNT_W),
            .SATURATE (SATURATE)
        ) u_cnt (
            .clk (clk),
            .rst (rst),
            .clr (clr),
            .inc (inc[i]),
            .q   (live_q[i]),
            .ovf (ovf[i])
        );
    end

    // Snapshot takes the pre-edge live values, so snap+clr is an atomic read-and-clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                snap_q[i] <= '0;
            end
        end else if (snap) begin
            snap_q <= live_q;
        end
    end

    // Index 7 has no counter behind it and falls through to zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (rd_sel == 3'(i)) begin
                rd_mux = rd_src ? snap_q[i] : live_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_mux;
        end
    end

endmodule

// File: tb/tb_perf_stats.sv
// tb/tb_perf_stats.sv - self-checking bench for perf_stats (32-bit wrap, 4-bit wrap, 4-bit saturate)
module tb_perf_stats;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, instr_valid, run, clr, snap, rd_src;
    logic [5:0] op;
    logic [2:0] rd_sel;
    logic [31:0] rd0;
    logic [3:0]  rd1, rd2;
    logic [6:0]  ovf0, ovf1, ovf2;

    perf_stats #(.CNT_W(32), .SATURATE(0)) u_w32 (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .op(op), .run(run), .clr(clr),
        .snap(snap), .rd_sel(rd_sel), .rd_src(rd_src), .rd_data(rd0), .ovf(ovf0));
    perf_stats #(.CNT_W(4), .SATURATE(0)) u_w4w (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .op(op), .run(run), .clr(clr),
        .snap(snap), .rd_sel(rd_sel), .rd_src(rd_src), .rd_data(rd1), .ovf(ovf1));
    perf_stats #(.CNT_W(4), .SATURATE(1)) u_w4s (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .op(op), .run(run), .clr(clr),
        .snap(snap), .rd_sel(rd_sel), .rd_src(rd_src), .rd_data(rd2), .ovf(ovf2));

    int n_chk  = 0;
    int n_pass = 0;

    int cw [3] = '{32, 4, 4};
    int cs [3] = '{0, 0, 1};

    logic [63:0] m_live [3][7];
    logic [63:0] m_snp  [3][7];
    logic [6:0]  m_ovf  [3];

    typedef struct {
        string       name;
        logic [2:0]  sel;
        logic        src;
        logic [31:0] exp;
    } rd_vec_t;

    rd_vec_t mix_tab [8];
    logic [5:0] mix_ops [5];
    logic [5:0] known_ops [12];

    // Which counters one cycle bumps: index order CYCLES RTYPE ITYPE JTYPE MEM BRANCH UNKNOWN.
    function automatic logic [6:0] ref_hits(input logic [5:0] o, input logic v, input logic r);
        logic [6:0] h;
        h = '0;
        if (r) begin
            h[0] = 1'b1;
            if (v) begin
                if (o == 6'd0) h[1] = 1'b1;
                else if (o inside {6'd35, 6'd43, 6'd4, 6'd5, 6'd8, 6'd9, 6'd10, 6'd12, 6'd13}) begin
                    h[2] = 1'b1;
                    if (o inside {6'd35, 6'd43}) h[4] = 1'b1;
                    if (o inside {6'd4, 6'd5})   h[5] = 1'b1;
                end
                else if (o inside {6'd2, 6'd3}) h[3] = 1'b1;
                else h[6] = 1'b1;
            end
        end
        return h;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // One clock: drive inputs, advance the model, then compare every instance.
    task automatic cyc(input logic r, input logic v, input logic [5:0] o, input logic rn,
                       input logic c, input logic s, input logic [2:0] sel, input logic src);
        logic [63:0] exp_rd [3];
        logic [6:0]  h;
        logic [63:0] mx;
        rst = r; instr_valid = v; op = o; run = rn; clr = c; snap = s; rd_sel = sel; rd_src = src;
        h = ref_hits(o, v, rn);
        for (int k = 0; k < 3; k++) begin
            mx = (64'd1 << cw[k]) - 64'd1;
            if (r || sel == 3'd7) exp_rd[k] = '0;
            else exp_rd[k] = src ? m_snp[k][int'(sel)] : m_live[k][int'(sel)];
            if (r) begin
                for (int j = 0; j < 7; j++) begin
                    m_live[k][j] = '0;
                    m_snp[k][j]  = '0;
                end
                m_ovf[k] = '0;
            end else begin
                if (s) for (int j = 0; j < 7; j++) m_snp[k][j] = m_live[k][j];
                if (c) begin
                    for (int j = 0; j < 7; j++) m_live[k][j] = '0;
                    m_ovf[k] = '0;
                end else begin
                    for (int j = 0; j < 7; j++) begin
                        if (h[j]) begin
                            if (m_live[k][j] == mx) begin
                                m_ovf[k][j]  = 1'b1;
                                m_live[k][j] = (cs[k] != 0) ? mx : 64'd0;
                            end else begin
                                m_live[k][j] = m_live[k][j] + 64'd1;
                            end
                        end
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        chk("rd_data w32", {32'd0, rd0}, exp_rd[0]);
        chk("rd_data w4wrap", {60'd0, rd1}, exp_rd[1]);
        chk("rd_data w4sat", {60'd0, rd2}, exp_rd[2]);
        chk("ovf w32", {57'd0, ovf0}, {57'd0, m_ovf[0]});
        chk("ovf w4wrap", {57'd0, ovf1}, {57'd0, m_ovf[1]});
        chk("ovf w4sat", {57'd0, ovf2}, {57'd0, m_ovf[2]});
    endtask

    task automatic rd(input logic [2:0] sel, input logic src);
        cyc(1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, sel, src);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    endtask

    initial begin
        mix_ops = '{6'b000000, 6'b100011, 6'b000100, 6'b000010, 6'b111111};
        known_ops = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd8, 6'd9, 6'd10, 6'd12, 6'd13, 6'd35, 6'd43};
        mix_tab[0] = '{"mix CYCLES",  3'd0, 1'b0, 32'd5};
        mix_tab[1] = '{"mix RTYPE",   3'd1, 1'b0, 32'd1};
        mix_tab[2] = '{"mix ITYPE",   3'd2, 1'b0, 32'd2};
        mix_tab[3] = '{"mix JTYPE",   3'd3, 1'b0, 32'd1};
        mix_tab[4] = '{"mix MEM",     3'd4, 1'b0, 32'd1};
        mix_tab[5] = '{"mix BRANCH",  3'd5, 1'b0, 32'd1};
        mix_tab[6] = '{"mix UNKNOWN", 3'd6, 1'b0, 32'd1};
        mix_tab[7] = '{"mix sel7",    3'd7, 1'b0, 32'd0};

        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 7; j++) begin
                m_live[k][j] = '0;
                m_snp[k][j]  = '0;
            end
            m_ovf[k] = '0;
        end
        rst = 1'b1; instr_valid = 1'b0; op = '0; run = 1'b0; clr = 1'b0; snap = 1'b0;
        rd_sel = '0; rd_src = 1'b0;

        do_reset();
        do_reset();
        chk("reset rd_data", {32'd0, rd0}, 64'd0);
        chk("reset ovf", {57'd0, ovf0}, 64'd0);

        // opcode mix
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, mix_ops[i], 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            rd(mix_tab[i].sel, mix_tab[i].src);
            chk(mix_tab[i].name, {32'd0, rd0}, {32'd0, mix_tab[i].exp});
        end

        // bubbles then freeze
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        rd(3'd0, 1'b0);
        chk("freeze CYCLES", {32'd0, rd0}, 64'd3);
        for (int j = 1; j < 7; j++) begin
            rd(3'(j), 1'b0);
            chk($sformatf("freeze class %0d", j), {32'd0, rd0}, 64'd0);
        end

        // wrap versus saturate on 4-bit counters
        do_reset();
        for (int i = 0; i < 17; i++) cyc(1'b0, 1'b1, 6'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        rd(3'd1, 1'b0);
        chk("wrap RTYPE", {60'd0, rd1}, 64'd1);
        chk("sat RTYPE", {60'd0, rd2}, 64'd15);
        chk("wrap ovf[1]", {63'd0, ovf1[1]}, 64'd1);
        chk("sat ovf[1]", {63'd0, ovf2[1]}, 64'd1);
        cyc(1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        chk("clr ovf while frozen", {57'd0, ovf1}, 64'd0);

        // atomic read-and-clear
        do_reset();
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        cyc(1'b0, 1'b1, 6'd0, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0);
        rd(3'd0, 1'b1);
        chk("snap CYCLES", {32'd0, rd0}, 64'd10);
        rd(3'd0, 1'b0);
        chk("live CYCLES after clr", {32'd0, rd0}, 64'd0);
        rd(3'd1, 1'b0);
        chk("live RTYPE after clr", {32'd0, rd0}, 64'd0);
        chk("ovf after clr", {57'd0, ovf0}, 64'd0);

        // read latency, index 7, reset priority
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        cyc(1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        chk("latency CYCLES a", {32'd0, rd0}, 64'd4);
        cyc(1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        chk("latency CYCLES b", {32'd0, rd0}, 64'd5);
        rd(3'd7, 1'b0);
        chk("sel7 zero", {32'd0, rd0}, 64'd0);
        cyc(1'b0, 1'b1, 6'd0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0);
        cyc(1'b1, 1'b1, 6'd0, 1'b1, 1'b1, 1'b1, 3'd0, 1'b1);
        chk("rst prio rd_data", {32'd0, rd0}, 64'd0);
        rd(3'd0, 1'b1);
        chk("rst prio snap", {32'd0, rd0}, 64'd0);
        rd(3'd0, 1'b0);
        chk("rst prio live", {32'd0, rd0}, 64'd0);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [5:0] o;
            o = ($urandom_range(0, 3) != 0) ? known_ops[$urandom_range(0, 11)] : 6'($urandom);
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, o,
                $urandom_range(0, 9) < 8, $urandom_range(0, 39) == 0,
                $urandom_range(0, 7) == 0, 3'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
